// File: rtl/alu_packet_ctrl.sv
// Packet sequencer between the UART byte streams and the shared multi-cycle ALU.
// Parses opcode/LEN headers, chains operands through the ALU and streams back the 32-bit result.
module alu_packet_ctrl #(
    parameter int unsigned TimeoutCycles = 32250000,
    parameter logic [7:0]  OpEcho        = 8'hEC,
    parameter logic [7:0]  OpAdd         = 8'hA0,
    parameter logic [7:0]  OpMul         = 8'hA1,
    parameter logic [7:0]  OpDiv         = 8'hA2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [1:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic        alu_start_o,
    input  logic        alu_done_i,
    input  logic [31:0] alu_result_i,
    output logic        err_o
);

    localparam int unsigned TW = $clog2(TimeoutCycles + 1);
    localparam logic [TW-1:0] TmoLast = TW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_ECHO,
        S_OPERAND,
        S_ALU_WAIT,
        S_RESP,
        S_DROP
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     hdr_cnt_q, hdr_cnt_d;
    logic [7:0]     opcode_q, opcode_d;
    logic [7:0]     len_lo_q, len_lo_d;
    logic [15:0]    remain_q, remain_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [23:0]    opnd_q, opnd_d;
    logic           first_q, first_d;
    logic [31:0]    acc_q, acc_d;
    logic [31:0]    alu_a_q, alu_a_d;
    logic [31:0]    alu_b_q, alu_b_d;
    logic [1:0]     alu_op_q, alu_op_d;
    logic           alu_start_q, alu_start_d;
    logic           err_q, err_d;
    logic           tx_valid_q, tx_valid_d;
    logic [1:0]     resp_cnt_q, resp_cnt_d;
    logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;

    logic           rx_fire;
    logic           tmo_active;
    logic           tmo_fire;
    logic [TW-1:0]  tmo_inc;
    logic [15:0]    len_full;
    logic [15:0]    payload;
    logic [31:0]    word;
    logic           len_ok_arith;

    function automatic logic [1:0] op_sel(input logic [7:0] opc);
        if (opc == OpMul) return 2'd1;
        if (opc == OpDiv) return 2'd2;
        return 2'd0;
    endfunction

    assign len_full = {rx_data_i, len_lo_q};
    assign payload  = len_full - 16'd4;
    assign word     = {rx_data_i, opnd_q};
    assign len_ok_arith = ((opcode_q == OpAdd) || (opcode_q == OpMul))
                          && (payload != 16'd0) && (payload[1:0] == 2'b00);

    // The idle counter only runs while a packet is partially received.
    assign tmo_active = ((state_q == S_HDR) && (hdr_cnt_q != 2'd0)) || (state_q == S_ECHO)
                        || (state_q == S_OPERAND) || (state_q == S_DROP);
    assign tmo_inc    = tmo_cnt_q + TW'(1);
    assign tmo_fire   = tmo_active && (tmo_inc == TmoLast);

    assign alu_op_o    = alu_op_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_start_o = alu_start_q;
    assign err_o       = err_q;

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        opcode_d    = opcode_q;
        len_lo_d    = len_lo_q;
        remain_d    = remain_q;
        byte_cnt_d  = byte_cnt_q;
        opnd_d      = opnd_q;
        first_d     = first_q;
        acc_d       = acc_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_start_d = 1'b0;
        err_d       = 1'b0;
        tx_valid_d  = tx_valid_q;
        resp_cnt_d  = resp_cnt_q;
        tmo_cnt_d   = tmo_active ? tmo_inc : '0;

        rx_ready_o = 1'b0;
        tx_valid_o = tx_valid_q;
        case (resp_cnt_q)
            2'd0:    tx_data_o = acc_q[7:0];
            2'd1:    tx_data_o = acc_q[15:8];
            2'd2:    tx_data_o = acc_q[23:16];
            default: tx_data_o = acc_q[31:24];
        endcase

        case (state_q)
            S_HDR, S_OPERAND, S_DROP: rx_ready_o = 1'b1;
            S_ECHO: begin
                rx_ready_o = tx_ready_i;
                tx_valid_o = rx_valid_i && !tmo_fire;
                tx_data_o  = rx_data_i;
            end
            default: rx_ready_o = 1'b0;
        endcase
        if (tmo_fire) rx_ready_o = 1'b0;

        rx_fire = rx_valid_i && rx_ready_o;
        if (rx_fire) tmo_cnt_d = '0;

        case (state_q)
            S_HDR: begin
                if (rx_fire) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    case (hdr_cnt_q)
                        2'd0: opcode_d = rx_data_i;
                        2'd2: len_lo_d = rx_data_i;
                        2'd3: begin
                            byte_cnt_d = 2'd0;
                            first_d    = 1'b1;
                            remain_d   = payload;
                            if (len_full < 16'd4) begin
                                err_d = 1'b1;
                            end else if (opcode_q == OpEcho) begin
                                if (payload != 16'd0) state_d = S_ECHO;
                            end else if (len_ok_arith || ((opcode_q == OpDiv) && (payload == 16'd8))) begin
                                state_d = S_OPERAND;
                            end else begin
                                err_d = 1'b1;
                                if (payload != 16'd0) state_d = S_DROP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_ECHO, S_DROP: begin
                if (rx_fire) begin
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) state_d = S_HDR;
                end
            end
            S_OPERAND: begin
                if (rx_fire) begin
                    remain_d   = remain_q - 16'd1;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: opnd_d[7:0]   = rx_data_i;
                        2'd1: opnd_d[15:8]  = rx_data_i;
                        2'd2: opnd_d[23:16] = rx_data_i;
                        default: begin
                            if (first_q) begin
                                // First operand seeds the accumulator without an ALU pass.
                                acc_d   = word;
                                first_d = 1'b0;
                                if (remain_q == 16'd1) begin
                                    state_d    = S_RESP;
                                    tx_valid_d = 1'b1;
                                    resp_cnt_d = 2'd0;
                                end
                            end else begin
                                alu_a_d     = acc_q;
                                alu_b_d     = word;
                                alu_op_d    = op_sel(opcode_q);
                                alu_start_d = 1'b1;
                                state_d     = S_ALU_WAIT;
                            end
                        end
                    endcase
                end
            end
            S_ALU_WAIT: begin
                if (alu_done_i) begin
                    acc_d = alu_result_i;
                    if (remain_q == 16'd0) begin
                        state_d    = S_RESP;
                        tx_valid_d = 1'b1;
                        resp_cnt_d = 2'd0;
                    end else begin
                        state_d = S_OPERAND;
                    end
                end
            end
            S_RESP: begin
                if (tx_valid_q && tx_ready_i) begin
                    resp_cnt_d = resp_cnt_q + 2'd1;
                    if (resp_cnt_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_HDR;
                    end
                end
            end
            default: state_d = S_HDR;
        endcase

        if (tmo_fire) begin
            state_d   = S_HDR;
            hdr_cnt_d = 2'd0;
            err_d     = 1'b1;
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_HDR;
            hdr_cnt_q   <= 2'd0;
            opcode_q    <= 8'd0;
            len_lo_q    <= 8'd0;
            remain_q    <= 16'd0;
            byte_cnt_q  <= 2'd0;
            opnd_q      <= 24'd0;
            first_q     <= 1'b0;
            acc_q       <= 32'd0;
            alu_a_q     <= 32'd0;
            alu_b_q     <= 32'd0;
            alu_op_q    <= 2'd0;
            alu_start_q <= 1'b0;
            err_q       <= 1'b0;
            tx_valid_q  <= 1'b0;
            resp_cnt_q  <= 2'd0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            opcode_q    <= opcode_d;
            len_lo_q    <= len_lo_d;
            remain_q    <= remain_d;
            byte_cnt_q  <= byte_cnt_d;
            opnd_q      <= opnd_d;
            first_q     <= first_d;
            acc_q       <= acc_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_start_q <= alu_start_d;
            err_q       <= err_d;
            tx_valid_q  <= tx_valid_d;
            resp_cnt_q  <= resp_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

endmodule
